// File: rtl/host_io_pkg.sv
// host_io_pkg: shared state enum and constants for the host I/O monitor
package host_io_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
  localparam logic [7:0] NEWLINE = 8'h0A;
  localparam int LANE_OFFS_W = 3;
endpackage

// File: rtl/host_io_fifo.sv
// host_io_fifo: synchronous FIFO, drops pushes when full unless a pop frees a slot
module host_io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
  always_comb begin
    do_pop = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = data_i;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) mem_q <= mem_d;
endmodule

// File: rtl/host_io_monitor.sv
// host_io_monitor: snoops mem writes for stdout chars and tohost exit; HOST_IO_MONITOR_LINE_CNT_EN adds line_count_o
module host_io_monitor
  import host_io_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    DATA_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] STDOUT_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = '0,
  parameter int                    FIFO_DEPTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_we_i,
  input  logic [ADDR_WIDTH-1:0]   mem_waddr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i,
  output logic [7:0]              char_o,
  output logic                    char_valid_o,
  input  logic                    char_ready_i,
  output logic                    exit_valid_o,
  output logic [63:0]             exit_code_o,
`ifdef HOST_IO_MONITOR_LINE_CNT_EN
  output logic                    overflow_o,
  output logic [31:0]             line_count_o
`else
  output logic                    overflow_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LANE_OFFS_W-1:0] S_LANE = STDOUT_ADDR[LANE_OFFS_W-1:0];
  state_e state_q, state_d;
  logic exit_valid_q, exit_valid_d, overflow_q, overflow_d;
  logic [63:0] exit_code_q, exit_code_d, code_w;
  logic stdout_hit, tohost_hit, push, pop, acc, full, empty;
  logic [7:0] ch;
  logic [CW-1:0] count;
  logic addr_lo_unused;
  assign addr_lo_unused = ^mem_waddr_i[LANE_OFFS_W-1:0];
  host_io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(push),
    .data_i(ch),
    .pop_i(pop),
    .full_o(full),
    .empty_o(empty),
    .head_o(char_o),
    .count_o(count)
  );
  assign char_valid_o = !empty;
  assign exit_valid_o = exit_valid_q;
  assign exit_code_o = exit_code_q;
  assign overflow_o = overflow_q;
  always_comb begin
    stdout_hit = mem_we_i && mem_wstrb_i[S_LANE]
      && mem_waddr_i[ADDR_WIDTH-1:LANE_OFFS_W] == STDOUT_ADDR[ADDR_WIDTH-1:LANE_OFFS_W];
    tohost_hit = mem_we_i && |mem_wstrb_i
      && mem_waddr_i[ADDR_WIDTH-1:LANE_OFFS_W] == TOHOST_ADDR[ADDR_WIDTH-1:LANE_OFFS_W];
    ch = mem_wdata_i[8*S_LANE +: 8];
    push = state_q == RUN && stdout_hit;
    pop = !empty && char_ready_i;
    acc = push && (!full || pop);
    overflow_d = overflow_q || (push && full && !pop);
    code_w = '0;
    for (int i = 0; i < 8; i++) code_w[8*i +: 8] = mem_wstrb_i[i] ? mem_wdata_i[8*i +: 8] : 8'h00;
    exit_valid_d = state_q == DONE;
    exit_code_d = exit_code_q;
    state_d = state_q;
    if (state_q == RUN && tohost_hit) begin
      exit_code_d = code_w;
      state_d = (empty && !push) ? DONE : DRAIN;
    end
    if (state_q == DRAIN && (empty || (count == CW'(1) && pop))) state_d = DONE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      exit_valid_q <= 1'b0;
      exit_code_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q <= exit_code_d;
      overflow_q <= overflow_d;
    end
  end
`ifdef HOST_IO_MONITOR_LINE_CNT_EN
  logic [31:0] line_q, line_d;
  assign line_count_o = line_q;
  always_comb line_d = (acc && ch == NEWLINE && !(&line_q)) ? line_q + 32'd1 : line_q;
  always_ff @(posedge clk_i) line_q <= rst_i ? 32'd0 : line_d;
`else
  logic acc_unused;
  assign acc_unused = acc;
`endif
endmodule

// File: tb/tb_host_io_monitor.sv
// tb_host_io_monitor: vector table plus scoreboarded multi-cycle sequences for host_io_monitor
module tb_host_io_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_we = 1'b0;
  logic char_ready = 1'b0;
  logic [63:0] mem_waddr = '0;
  logic [63:0] mem_wdata = '0;
  logic [7:0] mem_wstrb = '0;
  logic [7:0] char_o;
  logic char_valid, exit_valid, overflow;
  logic [63:0] exit_code;
`ifdef HOST_IO_MONITOR_LINE_CNT_EN
  logic [31:0] line_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];
  typedef struct {
    logic we;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0] strb;
    logic exp_push;
    logic [7:0] exp_char;
  } vec_t;
  vec_t vecs [7];
  always #5 clk = ~clk;
  host_io_monitor #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64),
    .STDOUT_ADDR(64'h1003),
    .TOHOST_ADDR(64'h2000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mem_we_i(mem_we),
    .mem_waddr_i(mem_waddr),
    .mem_wdata_i(mem_wdata),
    .mem_wstrb_i(mem_wstrb),
    .char_o(char_o),
    .char_valid_o(char_valid),
    .char_ready_i(char_ready),
    .exit_valid_o(exit_valid),
    .exit_code_o(exit_code),
`ifdef HOST_IO_MONITOR_LINE_CNT_EN
    .overflow_o(overflow),
    .line_count_o(line_count)
`else
    .overflow_o(overflow)
`endif
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (char_valid && char_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_char: got %0h expected none", char_o);
      end else check("char_o", 64'(char_o), 64'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic we, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    mem_we = we;
    mem_waddr = a;
    mem_wdata = d;
    mem_wstrb = s;
    step();
    mem_we = 1'b0;
  endtask
  task automatic putc(input logic [7:0] c, input bit exp);
    if (exp) sb.push_back(c);
    wr(1'b1, 64'h1000, 64'(c) << 24, 8'h08);
  endtask
  task automatic do_reset();
    sb.delete();
    rst = 1'b1;
    mem_we = 1'b0;
    char_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(char_valid), 64'h0);
    check({tag, "_char"}, 64'(char_o), 64'h0);
    check({tag, "_exit_valid"}, 64'(exit_valid), 64'h0);
    check({tag, "_exit_code"}, exit_code, 64'h0);
    check({tag, "_overflow"}, 64'(overflow), 64'h0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{1'b1, 64'h1000, 64'h41 << 24, 8'h08, 1'b1, 8'h41};
    vecs[1] = '{1'b1, 64'h1000, 64'h41 << 24, 8'h01, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 64'h1008, 64'h42 << 24, 8'hFF, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 64'h1000, 64'hFFFF_FFFF_5AFF_FFFF, 8'hFF, 1'b1, 8'h5A};
    vecs[4] = '{1'b1, 64'h0000, 64'h43 << 24, 8'h08, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 64'h1000, 64'h44 << 24, 8'h08, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 64'h1000, 64'h0A << 24, 8'h08, 1'b1, 8'h0A};
    do_reset();
    check_reset_outputs("reset");
    char_ready = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].exp_push) sb.push_back(vecs[i].exp_char);
      wr(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].strb);
      check($sformatf("vec%0d_valid_n1", i), 64'(char_valid), 64'(vecs[i].exp_push));
      step();
      check($sformatf("vec%0d_valid_n2", i), 64'(char_valid), 64'h0);
    end
    check("vec_sb_empty", 64'(sb.size()), 64'h0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      putc(8'h30 + 8'(i), i < 4);
      if (i == 3) check("ovf_before", 64'(overflow), 64'h0);
      if (i == 4) check("ovf_after", 64'(overflow), 64'h1);
    end
    char_ready = 1'b1;
    repeat (4) step();
    check("ovf_drained_valid", 64'(char_valid), 64'h0);
    check("ovf_sb_empty", 64'(sb.size()), 64'h0);
    check("ovf_sticky", 64'(overflow), 64'h1);
    do_reset();
    wr(1'b1, 64'h2000, 64'h1122_3344_5566_7788, 8'h0F);
    check("exit_code", exit_code, 64'h0000_0000_5566_7788);
    check("exit_valid_lag", 64'(exit_valid), 64'h0);
    step();
    check("exit_valid", 64'(exit_valid), 64'h1);
    char_ready = 1'b1;
    wr(1'b1, 64'h2000, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    putc(8'h41, 1'b0);
    step();
    check("exit_code_held", exit_code, 64'h0000_0000_5566_7788);
    check("done_no_char", 64'(char_valid), 64'h0);
    check("exit_valid_sticky", 64'(exit_valid), 64'h1);
    do_reset();
    putc(8'h48, 1'b1);
    putc(8'h69, 1'b1);
    wr(1'b1, 64'h2000, 64'h1, 8'hFF);
    check("drain_exit_low", 64'(exit_valid), 64'h0);
    check("drain_code", exit_code, 64'h1);
    putc(8'h7A, 1'b0);
    check("drain_head", 64'(char_o), 64'h48);
    check("drain_exit_low2", 64'(exit_valid), 64'h0);
    char_ready = 1'b1;
    for (int i = 0; i < 10 && !exit_valid; i++) step();
    check("drain_exit_rise", 64'(exit_valid), 64'h1);
    check("drain_order", 64'(sb.size()), 64'h0);
    step();
    check("drain_no_extra", 64'(char_valid), 64'h0);
    do_reset();
    for (int i = 0; i < 5; i++) putc(8'h61 + 8'(i), 1'b0);
    wr(1'b1, 64'h2000, 64'h55, 8'h01);
    check("rst_pre_ovf", 64'(overflow), 64'h1);
    check("rst_pre_code", exit_code, 64'h55);
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    char_ready = 1'b1;
    putc(8'h42, 1'b1);
    step();
    check("post_rst_sb", 64'(sb.size()), 64'h0);
`ifdef HOST_IO_MONITOR_LINE_CNT_EN
    do_reset();
    char_ready = 1'b1;
    putc(8'h41, 1'b1);
    putc(8'h0A, 1'b1);
    putc(8'h42, 1'b1);
    putc(8'h0A, 1'b1);
    repeat (3) step();
    check("line_count", 64'(line_count), 64'd2);
    check("line_sb", 64'(sb.size()), 64'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
